// File: rtl/tetris_pixel_gen_if.sv
// Video-timing, board-RAM read port and pixel-output bundle of the
// TetriSaraj playfield renderer.
interface tetris_pixel_gen_if;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [7:0]  board_addr;
  logic [2:0]  board_data;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output video_on, hsync_in, vsync_in, x, y, board_data,
    input  board_addr, rgb, hsync, vsync, frame_start
  );

  modport slave (
    input  video_on, hsync_in, vsync_in, x, y, board_data,
    output board_addr, rgb, hsync, vsync, frame_start
  );
endinterface

// File: rtl/tetris_pixel_gen.sv
// Playfield pixel generator: maps the VGA scan onto the 10x20 board, reads
// the cell colour from the board RAM and emits RGB/sync on a 3-clk pipeline.
module tetris_pixel_gen #(
  parameter int BX0  = 220,
  parameter int BY0  = 40,
  parameter int CELL = 20,
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int WALL = 4,
  parameter int HMAX = 799
) (
  input  logic               clk,
  input  logic               reset,
  tetris_pixel_gen_if.slave  bus
);

  localparam int BW = COLS * CELL;
  localparam int BH = ROWS * CELL;
  localparam int SW = $clog2(CELL);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [9:0] X_LO  = 10'(BX0);
  localparam logic [9:0] X_HI  = 10'(BX0 + BW);
  localparam logic [9:0] Y_LO  = 10'(BY0);
  localparam logic [9:0] Y_HI  = 10'(BY0 + BH);
  localparam logic [9:0] WX_LO = 10'(BX0 - WALL);
  localparam logic [9:0] WX_HI = 10'(BX0 + BW + WALL);
  localparam logic [9:0] WY_LO = 10'(BY0 - WALL);
  localparam logic [9:0] WY_HI = 10'(BY0 + BH + WALL);
  localparam logic [9:0] Y_PRE = 10'(BY0 - 1);
  localparam logic [9:0] X_END = 10'(HMAX);

  localparam logic [SW-1:0] SUB_LAST = SW'(CELL - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [7:0]    COLS_V   = 8'(COLS);

  typedef enum logic [1:0] {
    CLS_OFF  = 2'd0,
    CLS_BG   = 2'd1,
    CLS_WALL = 2'd2,
    CLS_INT  = 2'd3
  } cls_t;

  logic          in_x, in_y, in_wx, in_wy, line_end;
  logic [SW-1:0] col_sub_q, col_sub_cur, row_sub_q;
  logic [CW-1:0] col_idx_q, col_idx_cur;
  logic [RW-1:0] row_idx_q;

  cls_t          cls_d, cls_s1, cls_s2;
  logic          grid_d, grid_s1, grid_s2;
  logic [7:0]    addr_d, addr_q;
  // {frame_start, vsync, hsync} travelling alongside the pixel
  logic [2:0]    tag_d, tag_s1, tag_s2, tag_s3;
  logic [11:0]   pal_colour, pix_d, rgb_q;

  always_comb begin
    in_x     = (bus.x >= X_LO)  && (bus.x < X_HI);
    in_y     = (bus.y >= Y_LO)  && (bus.y < Y_HI);
    in_wx    = (bus.x >= WX_LO) && (bus.x < WX_HI);
    in_wy    = (bus.y >= WY_LO) && (bus.y < WY_HI);
    line_end = (bus.x == X_END);
  end

  // The left edge forces the column position to zero in the same cycle, so
  // the stored counter always holds the position of the following pixel.
  always_comb begin
    col_sub_cur = col_sub_q;
    col_idx_cur = col_idx_q;
    if (bus.x == X_LO) begin
      col_sub_cur = '0;
      col_idx_cur = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_sub_q <= '0;
      col_idx_q <= '0;
    end else if (in_x) begin
      if (col_sub_cur == SUB_LAST) begin
        col_sub_q <= '0;
        col_idx_q <= (col_idx_cur == COL_LAST) ? col_idx_cur : col_idx_cur + 1'b1;
      end else begin
        col_sub_q <= col_sub_cur + 1'b1;
        col_idx_q <= col_idx_cur;
      end
    end
  end

  // Row position changes only at the end of a line, ready for the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_sub_q <= '0;
      row_idx_q <= '0;
    end else if (line_end) begin
      if (bus.y == Y_PRE) begin
        row_sub_q <= '0;
        row_idx_q <= '0;
      end else if (in_y) begin
        if (row_sub_q == SUB_LAST) begin
          row_sub_q <= '0;
          row_idx_q <= (row_idx_q == ROW_LAST) ? row_idx_q : row_idx_q + 1'b1;
        end else begin
          row_sub_q <= row_sub_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cls_d = CLS_BG;
    if (!bus.video_on)
      cls_d = CLS_OFF;
    else if (in_x && in_y)
      cls_d = CLS_INT;
    else if (in_wx && in_wy)
      cls_d = CLS_WALL;
    grid_d = (col_sub_cur == '0) || (row_sub_q == '0);
    addr_d = 8'(row_idx_q) * COLS_V + 8'(col_idx_cur);
    tag_d  = {(bus.x == '0) && (bus.y == '0), bus.vsync_in, bus.hsync_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      cls_s1  <= CLS_OFF;
      grid_s1 <= 1'b0;
      tag_s1  <= '0;
    end else begin
      if (cls_d == CLS_INT)
        addr_q <= addr_d;
      cls_s1  <= cls_d;
      grid_s1 <= grid_d;
      tag_s1  <= tag_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_s2  <= CLS_OFF;
      grid_s2 <= 1'b0;
      tag_s2  <= '0;
    end else begin
      cls_s2  <= cls_s1;
      grid_s2 <= grid_s1;
      tag_s2  <= tag_s1;
    end
  end

  // board_data answers the address registered one stage earlier.
  always_comb begin
    pal_colour = 12'h111;
    case (bus.board_data)
      3'd0: pal_colour = 12'h111;
      3'd1: pal_colour = 12'h0FF;
      3'd2: pal_colour = 12'hFF0;
      3'd3: pal_colour = 12'hA0F;
      3'd4: pal_colour = 12'h0F0;
      3'd5: pal_colour = 12'hF00;
      3'd6: pal_colour = 12'h00F;
      3'd7: pal_colour = 12'hF80;
      default: pal_colour = 12'h111;
    endcase
  end

  always_comb begin
    pix_d = 12'h000;
    case (cls_s2)
      CLS_WALL: pix_d = 12'h888;
      CLS_INT:  pix_d = grid_s2 ? 12'h333 : pal_colour;
      default:  pix_d = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q  <= '0;
      tag_s3 <= '0;
    end else begin
      rgb_q  <= pix_d;
      tag_s3 <= tag_s2;
    end
  end

  assign bus.board_addr  = addr_q;
  assign bus.rgb         = rgb_q;
  assign bus.hsync       = tag_s3[0];
  assign bus.vsync       = tag_s3[1];
  assign bus.frame_start = tag_s3[2];

endmodule

// File: tb/tb_tetris_pixel_gen.sv
// Scoreboard bench for tetris_pixel_gen: a compressed-frame timing driver
// queues expected outputs, a negedge monitor pops and compares them.
module tb_tetris_pixel_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tetris_pixel_gen_if bus ();

  tetris_pixel_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [11:0] PAL [8] = '{12'h111, 12'h0FF, 12'hFF0, 12'hA0F,
                                      12'h0F0, 12'hF00, 12'h00F, 12'hF80};

  typedef struct {
    int          due;
    int          px;
    int          py;
    bit          chk_rgb;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } pix_t;

  typedef struct {
    int         due;
    int         px;
    int         py;
    logic [7:0] addr;
  } adr_t;

  pix_t q_pix[$];
  adr_t q_adr[$];
  pix_t mp;
  adr_t ma;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [2:0] ram [0:199];
  bit         trusted    = 1'b0;
  bit         addr_known = 1'b0;
  logic [7:0] last_addr  = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read board RAM
  always @(posedge clk)
    bus.board_data <= (bus.board_addr < 8'd200) ? ram[bus.board_addr] : 3'd0;

  task automatic cmp(string name, int px, int py, logic [11:0] got, logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at (%0d,%0d): got %h expected %h", name, px, py, got, exp);
    end
  endtask

  function automatic bit in_int(int px, int py);
    return (px >= 220) && (px < 420) && (py >= 40) && (py < 440);
  endfunction

  function automatic logic [11:0] model_rgb(int px, int py, bit von);
    int c, r, cs, rs;
    if (!von) return 12'h000;
    if (in_int(px, py)) begin
      c  = (px - 220) / 20;
      cs = (px - 220) % 20;
      r  = (py - 40) / 20;
      rs = (py - 40) % 20;
      if (cs == 0 || rs == 0) return 12'h333;
      return PAL[ram[r * 10 + c]];
    end
    if ((px >= 216) && (px < 424) && (py >= 36) && (py < 444)) return 12'h888;
    return 12'h000;
  endfunction

  function automatic bit is_detail(int py);
    case (py)
      36, 37, 39, 40, 41, 59, 60, 61, 75, 100, 200,
      239, 240, 300, 438, 439, 440, 443, 444: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q_pix.size() != 0 && q_pix[0].due <= cyc) begin
      mp = q_pix.pop_front();
      cmp("hsync", mp.px, mp.py, 12'(bus.hsync), 12'(mp.hs));
      cmp("vsync", mp.px, mp.py, 12'(bus.vsync), 12'(mp.vs));
      cmp("frame_start", mp.px, mp.py, 12'(bus.frame_start), 12'(mp.fs));
      if (mp.chk_rgb) cmp("rgb", mp.px, mp.py, bus.rgb, mp.rgb);
    end
    while (q_adr.size() != 0 && q_adr[0].due <= cyc) begin
      ma = q_adr.pop_front();
      cmp("board_addr", ma.px, ma.py, 12'(bus.board_addr), 12'(ma.addr));
    end
  end

  task automatic check_zero(string tag);
    cmp({tag, " rgb"}, -1, -1, bus.rgb, 12'h000);
    cmp({tag, " hsync"}, -1, -1, 12'(bus.hsync), 12'h000);
    cmp({tag, " vsync"}, -1, -1, 12'(bus.vsync), 12'h000);
    cmp({tag, " board_addr"}, -1, -1, 12'(bus.board_addr), 12'h000);
    cmp({tag, " frame_start"}, -1, -1, 12'(bus.frame_start), 12'h000);
  endtask

  // Called at posedge+1; returns at posedge+1 of the next cycle.
  task automatic drive(int px, int py);
    pix_t p;
    adr_t a;
    bit   von;
    von = (px < 640) && (py < 480);
    bus.x        = 10'(px);
    bus.y        = 10'(py);
    bus.video_on = von;
    bus.hsync_in = !((px >= 656) && (px < 752));
    bus.vsync_in = !((py >= 490) && (py < 492));
    p.due     = cyc + 3;
    p.px      = px;
    p.py      = py;
    p.chk_rgb = trusted;
    p.rgb     = model_rgb(px, py, von);
    p.hs      = bus.hsync_in;
    p.vs      = bus.vsync_in;
    p.fs      = (px == 0) && (py == 0);
    q_pix.push_back(p);
    if (trusted && von && in_int(px, py)) begin
      last_addr  = 8'(((py - 40) / 20) * 10 + (px - 220) / 20);
      addr_known = 1'b1;
    end
    if (trusted && addr_known) begin
      a.due  = cyc + 1;
      a.px   = px;
      a.py   = py;
      a.addr = last_addr;
      q_adr.push_back(a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    #1 reset = 1'b0;
    #1 check_zero("async_reset");
    q_pix.delete();
    q_adr.delete();
    trusted    = 1'b0;
    addr_known = 1'b0;
    @(posedge clk);
    #1 check_zero("held_reset");
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Compressed frame: every line shows x=0,100,700,799; detail lines also
  // scan 214..425 contiguously so the board counters see every board pixel.
  task automatic run_frame(int rst_y);
    for (int yy = 0; yy < 525; yy++) begin
      drive(0, yy);
      drive(100, yy);
      if (is_detail(yy)) begin
        for (int xx = 214; xx <= 425; xx++) begin
          drive(xx, yy);
          if (yy == rst_y && xx == 300) mid_reset();
        end
      end
      drive(700, yy);
      drive(799, yy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 200; i++) ram[i] = 3'(i % 8);
    ram[11]  = 3'd5;
    ram[199] = 3'd7;

    reset = 1'b0;
    #1 check_zero("reset_t0");
    for (int i = 0; i < 5; i++) begin
      bus.x        = 10'($urandom_range(0, 799));
      bus.y        = 10'($urandom_range(0, 524));
      bus.video_on = 1'($urandom);
      bus.hsync_in = 1'($urandom);
      bus.vsync_in = 1'($urandom);
      @(posedge clk);
      #1 check_zero("reset_hold");
    end

    reset      = 1'b1;
    trusted    = 1'b1;
    addr_known = 1'b1;
    last_addr  = 8'd0;
    run_frame(-1);

    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        ram[r * 10 + c] = ((r + c) % 2 == 1) ? 3'((r * 3 + c) % 7 + 1) : 3'd0;
    run_frame(200);

    trusted = 1'b1;
    run_frame(-1);

    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (q_pix.size() != 0 || q_adr.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d items left expected 0/0", q_pix.size(), q_adr.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
